// File: rtl/mw_writeback_stage.sv
// M->W pipeline register and write-back datapath.
// Holds the instruction leaving the memory stage, extends load data by type and
// byte offset, selects the write-back source and drives the register-file write
// port. A free-running counter tallies every valid instruction that leaves W.
module mw_writeback_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             stall,
  input  logic             M_valid,
  input  logic [31:0]      M_pc,
  input  logic [4:0]       M_a3,
  input  logic             M_we,
  input  logic [1:0]       M_wsel,
  input  logic [31:0]      M_alu,
  input  logic [31:0]      M_dm_rdata,
  input  logic [1:0]       M_addr_lo,
  input  logic [2:0]       M_ld_type,
  input  logic [31:0]      M_cp0_rd,
  output logic [31:0]      W_pc,
  output logic [4:0]       W_a3,
  output logic [31:0]      W_wd,
  output logic             W_we,
  output logic [CNT_W-1:0] W_retired
);

  localparam logic [1:0] WSEL_ALU  = 2'b00;
  localparam logic [1:0] WSEL_LOAD = 2'b01;
  localparam logic [1:0] WSEL_LINK = 2'b10;
  localparam logic [1:0] WSEL_CP0  = 2'b11;

  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LHU = 3'b010;
  localparam logic [2:0] LD_LB  = 3'b011;
  localparam logic [2:0] LD_LBU = 3'b100;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Extend the raw aligned memory word according to load type and byte offset.
  // Halfword selection uses only addr_lo[1]; misaligned halfwords never get here.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  lo,
                                              input logic [2:0]  ld_type);
    logic [15:0] half;
    logic [7:0]  byte_v;
    logic [31:0] res;
    half   = lo[1] ? word[31:16] : word[15:0];
    case (lo)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      2'd3:    byte_v = word[31:24];
      default: byte_v = word[7:0];
    endcase
    case (ld_type)
      LD_LW:   res = word;
      LD_LH:   res = {{16{half[15]}}, half};
      LD_LHU:  res = {16'h0000, half};
      LD_LB:   res = {{24{byte_v[7]}}, byte_v};
      LD_LBU:  res = {24'h00_0000, byte_v};
      default: res = word;
    endcase
    return res;
  endfunction

  // Pipeline state
  logic             valid_q,   valid_d;
  logic [31:0]      pc_q,      pc_d;
  logic [4:0]       a3_q,      a3_d;
  logic             we_q,      we_d;
  logic [1:0]       wsel_q,    wsel_d;
  logic [31:0]      alu_q,     alu_d;
  logic [31:0]      dm_q,      dm_d;
  logic [1:0]       lo_q,      lo_d;
  logic [2:0]       ld_q,      ld_d;
  logic [31:0]      cp0_q,     cp0_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [31:0]      ld_ext_s;
  logic [31:0]      wd_raw_s;
  logic             we_s;

  // Next-state: flush beats stall beats capture; the counter tracks departures.
  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    a3_d      = a3_q;
    we_d      = we_q;
    wsel_d    = wsel_q;
    alu_d     = alu_q;
    dm_d      = dm_q;
    lo_d      = lo_q;
    ld_d      = ld_q;
    cp0_d     = cp0_q;
    retired_d = retired_q;
    if (flush) begin
      valid_d = 1'b0;
      a3_d    = 5'd0;
      we_d    = 1'b0;
      pc_d    = RESET_PC;
    end else if (stall) begin
      valid_d = valid_q;
    end else begin
      valid_d = M_valid;
      pc_d    = M_pc;
      a3_d    = M_a3;
      we_d    = M_we;
      wsel_d  = M_wsel;
      alu_d   = M_alu;
      dm_d    = M_dm_rdata;
      lo_d    = M_addr_lo;
      ld_d    = M_ld_type;
      cp0_d   = M_cp0_rd;
    end
    if (valid_q && !stall) begin
      retired_d = retired_q + CNT_ONE;
    end else begin
      retired_d = retired_q;
    end
  end

  // State registers; reset discards the in-flight entry immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      pc_q      <= RESET_PC;
      a3_q      <= 5'd0;
      we_q      <= 1'b0;
      wsel_q    <= 2'b00;
      alu_q     <= 32'h0000_0000;
      dm_q      <= 32'h0000_0000;
      lo_q      <= 2'b00;
      ld_q      <= 3'b000;
      cp0_q     <= 32'h0000_0000;
      retired_q <= {CNT_W{1'b0}};
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      a3_q      <= a3_d;
      we_q      <= we_d;
      wsel_q    <= wsel_d;
      alu_q     <= alu_d;
      dm_q      <= dm_d;
      lo_q      <= lo_d;
      ld_q      <= ld_d;
      cp0_q     <= cp0_d;
      retired_q <= retired_d;
    end
  end

  // Write-back source select; writes to r0 and bubbles are suppressed.
  always_comb begin
    ld_ext_s = load_extend(dm_q, lo_q, ld_q);
    case (wsel_q)
      WSEL_ALU:  wd_raw_s = alu_q;
      WSEL_LOAD: wd_raw_s = ld_ext_s;
      WSEL_LINK: wd_raw_s = pc_q + 32'd8;
      WSEL_CP0:  wd_raw_s = cp0_q;
      default:   wd_raw_s = alu_q;
    endcase
    we_s = valid_q & we_q & (a3_q != 5'd0);
    if (we_s) begin
      W_a3 = a3_q;
      W_wd = wd_raw_s;
    end else begin
      W_a3 = 5'd0;
      W_wd = 32'h0000_0000;
    end
    W_we      = we_s;
    W_pc      = pc_q;
    W_retired = retired_q;
  end

endmodule
